cs_resolve: RTL and testbench
=============================

# cs_resolve

Sequential carry-propagate resolver for carry-save pairs. It accepts the two redundant outputs of the carry-save compressor tree and adds them chunk by chunk over several cycles to produce a single binary sum. The output is the sum modulo 2^input_width plus the carry out of the top bit. It sits directly downstream of the compressor in the datapath, so wide resolves run without a full-width ripple or prefix adder in one cycle.

## Interface
Parameters:
- input_width, 64, operand and sum width in bits; must be ≥ 1.
- chunk_width, 16, bits resolved per cycle; must satisfy 1 ≤ chunk_width ≤ input_width.
- verif_en, 0, when 1 enables simulation-only parameter and protocol assertions; has no effect on synthesized logic.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  reset, asynchronous, active-high.
- IN_VALID  input  1  an operand pair is offered.
- IN_READY  output  1  the block can accept an operand pair.
- IN0  input  input_width  carry-save operand 0.
- IN1  input  input_width  carry-save operand 1.
- OUT_VALID  output  1  SUM and CARRY_OUT hold a completed result.
- OUT_READY  input  1  the consumer takes the result.
- SUM  output  input_width  result (IN0 + IN1) mod 2^input_width.
- CARRY_OUT  output  1  carry out of bit input_width-1.

## Operation
- Chunk count: N = ceil(input_width / chunk_width). The last chunk covers only the remaining input_width − (N−1)·chunk_width bits.
- State machine states: IDLE, ADD, DONE.
- IDLE:
  - IN_READY = 1, OUT_VALID = 0.
  - When IN_VALID is high at a clock edge: latch IN0 and IN1 into operand registers, clear the carry register, set chunk index idx = 0, go to ADD.
- ADD:
  - IN_READY = 0, OUT_VALID = 0.
  - Each cycle computes {c, s} = op0[idx] + op1[idx] + carry, at chunk width.
  - s is written into the SUM register at chunk idx; c is written into the carry register; idx increments.
  - For the last chunk, the carry is taken from the bit just above that chunk's actual width, not from a full chunk_width.
  - The cycle that processes idx = N−1 loads CARRY_OUT and moves to DONE.
- DONE:
  - OUT_VALID = 1, IN_READY = 0.
  - SUM and CARRY_OUT hold stable.
  - When OUT_READY is high at a clock edge, go to IDLE. A new operand pair is accepted only from IDLE; there is no accept in the DONE handoff cycle.
- IN0 and IN1 are sampled only at the accept edge. Changes to them after that edge do not affect the result.
- SUM is meaningful only while OUT_VALID = 1. During ADD, partially written chunks are visible on SUM.
- Reset values, applied immediately on assertion: state = IDLE, IN_READY = 1, OUT_VALID = 0, SUM = 0, CARRY_OUT = 0, idx = 0, carry = 0.
- Reset asserted during ADD or DONE aborts the operation. The pending result is discarded and no OUT_VALID pulse is produced.
- OUT_READY while not in DONE, and IN_VALID while not in IDLE, are ignored.

## Timing
- Accept edge = edge 0. ADD runs on edges 1..N. OUT_VALID rises after edge N, so the result is visible N cycles after the accept edge.
- With OUT_READY held high, the minimum interval between consecutive accepts is N+2 cycles.
- Every output is a register output; there is no combinational path from inputs to outputs.
- Critical path: one chunk_width-bit adder plus carry-in, plus chunk-select muxing.

## Structure
- Shared package cs_resolve_pkg holds:
  - the state enum (IDLE, ADD, DONE);
  - a function num_chunks(input_width, chunk_width) returning the ceiling division.
- One sub-module, cs_chunk_add: a combinational chunk_width-bit adder with carry-in and carry-out, instantiated once and reused across cycles.
- With verif_en = 1, the block asserts:
  - the parameter constraints;
  - SUM stability while OUT_VALID is high and OUT_READY is low.

## Test plan
1. input_width = 64, chunk_width = 16. IN0 = 0xFFFF_FFFF_FFFF_FFFF, IN1 = 0x1 -> SUM = 0, CARRY_OUT = 1, OUT_VALID rises 4 cycles after the accept edge.
2. input_width = 60, chunk_width = 16 (partial last chunk). IN0 = 0xFFF_FFFF_FFFF_FFFF, IN1 = 0x1 -> SUM = 0, CARRY_OUT = 1. Then IN0 = 0x800_0000_0000_0000, IN1 = 0x7FF_FFFF_FFFF_FFFF -> SUM = 0xFFF_FFFF_FFFF_FFFF, CARRY_OUT = 0.
3. Backpressure: hold OUT_READY = 0 for 10 cycles after OUT_VALID rises -> SUM and CARRY_OUT stable, IN_READY = 0 and IN_VALID ignored. On the OUT_READY pulse, OUT_VALID falls and IN_READY = 1 on the next cycle.
4. Assert reset 2 cycles into ADD -> OUT_VALID = 0 and IN_READY = 1 immediately, SUM = 0. After release, a fresh operand pair 0x5 + 0x3 resolves to SUM = 0x8.
5. chunk_width = input_width = 64: N = 1, so OUT_VALID rises 1 cycle after the accept edge. 0x8000_0000_0000_0000 + 0x8000_0000_0000_0000 -> SUM = 0, CARRY_OUT = 1.
6. Randomized: 1000 operations with random IN_VALID and OUT_READY gaps. Every result matches the model {CARRY_OUT, SUM} = IN0 + IN1 at input_width+1 bits, and no result is lost or duplicated.

Source files
------------

// File: rtl/cs_resolve_pkg.sv
// Shared types and helpers for the carry-save resolver.
package cs_resolve_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } state_e;

    function automatic int num_chunks(input int iw, input int cw);
        return (iw + cw - 1) / cw;
    endfunction

endpackage

// File: rtl/cs_chunk_add.sv
// One chunk of the resolver: a plain adder with carry-in and carry-out.
module cs_chunk_add #(
    parameter int width = 16
) (
    input  logic [width-1:0] a,
    input  logic [width-1:0] b,
    input  logic             cin,
    output logic [width-1:0] s,
    output logic             cout
);

    assign {cout, s} = {1'b0, a} + {1'b0, b} + {{width{1'b0}}, cin};

endmodule

// File: rtl/cs_resolve.sv
// Resolves a carry-save pair into a binary sum, one chunk per cycle,
// reusing a single chunk adder.
module cs_resolve
    import cs_resolve_pkg::*;
#(
    parameter int input_width = 64,
    parameter int chunk_width = 16,
    parameter bit verif_en    = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   IN_VALID,
    output logic                   IN_READY,
    input  logic [input_width-1:0] IN0,
    input  logic [input_width-1:0] IN1,
    output logic                   OUT_VALID,
    input  logic                   OUT_READY,
    output logic [input_width-1:0] SUM,
    output logic                   CARRY_OUT
);

    localparam int N   = num_chunks(input_width, chunk_width);
    localparam int PW  = N * chunk_width;
    localparam int LW  = input_width - (N - 1) * chunk_width;
    localparam int LWI = LW % chunk_width;
    localparam int IW  = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    state_e                 state_q, state_d;
    logic [input_width-1:0] op0_q, op0_d;
    logic [input_width-1:0] op1_q, op1_d;
    logic [input_width-1:0] sum_q, sum_d;
    logic [input_width-1:0] sum_wr;
    logic                   carry_q, carry_d;
    logic                   cout_q, cout_d;
    logic [IW-1:0]          idx_q, idx_d;

    logic [PW-1:0]          op0_pad, op1_pad;
    logic [chunk_width-1:0] a_arr [N];
    logic [chunk_width-1:0] b_arr [N];
    logic [chunk_width-1:0] a_c, b_c, s_c;
    logic                   c_c, c_top;

    // Zero padding above input_width keeps the last chunk's adder honest.
    assign op0_pad = PW'(op0_q);
    assign op1_pad = PW'(op1_q);

    for (genvar k = 0; k < N; k++) begin : g_ch
        assign a_arr[k] = op0_pad[k*chunk_width +: chunk_width];
        assign b_arr[k] = op1_pad[k*chunk_width +: chunk_width];
    end

    assign a_c = a_arr[idx_q];
    assign b_c = b_arr[idx_q];

    cs_chunk_add #(
        .width (chunk_width)
    ) u_add (
        .a    (a_c),
        .b    (b_c),
        .cin  (carry_q),
        .s    (s_c),
        .cout (c_c)
    );

    for (genvar i = 0; i < input_width; i++) begin : g_wr
        assign sum_wr[i] = (idx_q == IW'(i / chunk_width))
                         ? s_c[i % chunk_width] : sum_q[i];
    end

    // A short last chunk carries out of bit LW, not out of the adder top.
    assign c_top = (LW == chunk_width) ? c_c : s_c[LWI];

    always_comb begin
        state_d = state_q;
        op0_d   = op0_q;
        op1_d   = op1_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                if (IN_VALID) begin
                    op0_d   = IN0;
                    op1_d   = IN1;
                    carry_d = 1'b0;
                    idx_d   = '0;
                    state_d = ADD;
                end
            end
            ADD: begin
                sum_d   = sum_wr;
                carry_d = c_c;
                if (idx_q == LAST) begin
                    cout_d  = c_top;
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            DONE: begin
                if (OUT_READY) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            op0_q   <= '0;
            op1_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            op0_q   <= op0_d;
            op1_q   <= op1_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            idx_q   <= idx_d;
        end
    end

    assign IN_READY  = (state_q == IDLE);
    assign OUT_VALID = (state_q == DONE);
    assign SUM       = sum_q;
    assign CARRY_OUT = cout_q;

    if (verif_en) begin : g_chk
        a_param: assert property (@(posedge clk)
            input_width >= 1 && chunk_width >= 1 &&
            chunk_width <= input_width);
        a_hold: assert property (@(posedge clk) disable iff (reset)
            (OUT_VALID && !OUT_READY) |=> ($stable(SUM) && $stable(CARRY_OUT)));
    end

endmodule

// File: tb/tb_cs_resolve.sv
// Bench for cs_resolve: three instances (64/16, 60/16, 64/64) checked
// against constant tables and a width-aware sum model via per-DUT queues.
module tb_cs_resolve;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  iv;
    logic [2:0]  ordy;
    logic [63:0] a_in [3];
    logic [63:0] b_in [3];
    wire  [2:0]  ir, ov, co;
    wire  [63:0] sum0, sum2;
    wire  [59:0] sum60;

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    int acc_cyc [3];
    bit ovp [3];
    logic [64:0] sbq [3][$];

    typedef struct {
        int          d;
        logic [63:0] a;
        logic [63:0] b;
        logic [64:0] e;
    } vec_t;
    vec_t vt [9];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cs_resolve #(.input_width(64), .chunk_width(16), .verif_en(1)) u0 (
        .clk(clk), .reset(reset),
        .IN_VALID(iv[0]), .IN_READY(ir[0]),
        .IN0(a_in[0]), .IN1(b_in[0]),
        .OUT_VALID(ov[0]), .OUT_READY(ordy[0]),
        .SUM(sum0), .CARRY_OUT(co[0])
    );

    cs_resolve #(.input_width(60), .chunk_width(16), .verif_en(1)) u1 (
        .clk(clk), .reset(reset),
        .IN_VALID(iv[1]), .IN_READY(ir[1]),
        .IN0(a_in[1][59:0]), .IN1(b_in[1][59:0]),
        .OUT_VALID(ov[1]), .OUT_READY(ordy[1]),
        .SUM(sum60), .CARRY_OUT(co[1])
    );

    cs_resolve #(.input_width(64), .chunk_width(64), .verif_en(1)) u2 (
        .clk(clk), .reset(reset),
        .IN_VALID(iv[2]), .IN_READY(ir[2]),
        .IN0(a_in[2]), .IN1(b_in[2]),
        .OUT_VALID(ov[2]), .OUT_READY(ordy[2]),
        .SUM(sum2), .CARRY_OUT(co[2])
    );

    function automatic int width_of(int d);
        return (d == 1) ? 60 : 64;
    endfunction

    function automatic int nch(int d);
        return (d == 2) ? 1 : 4;
    endfunction

    function automatic logic [64:0] model(int w, logic [63:0] a, logic [63:0] b);
        logic [63:0] m;
        logic [64:0] t;
        m = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        t = {1'b0, a & m} + {1'b0, b & m};
        return {t[w], t[63:0] & m};
    endfunction

    function automatic logic [64:0] got(int d);
        if (d == 0) return {co[0], sum0};
        if (d == 1) return {co[1], 4'b0, sum60};
        return {co[2], sum2};
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_mon
        always @(negedge clk) begin
            logic [64:0] e;
            if (!reset) begin
                if (ov[g] && !ovp[g]) begin
                    n_vec++;
                    if (cyc - acc_cyc[g] != nch(g)) begin
                        n_bad++;
                        $display("FAIL latency dut%0d: got %0d want %0d",
                                 g, cyc - acc_cyc[g], nch(g));
                    end
                end
                if (ov[g] && ordy[g]) begin
                    n_vec++;
                    if (sbq[g].size() == 0) begin
                        n_bad++;
                        $display("FAIL extra_result dut%0d: got %h want none",
                                 g, got(g));
                    end else begin
                        e = sbq[g].pop_front();
                        if (got(g) !== e) begin
                            n_bad++;
                            $display("FAIL result dut%0d: got %h want %h",
                                     g, got(g), e);
                        end
                    end
                end
            end
            ovp[g] = ov[g];
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic op(int d, logic [63:0] a, logic [63:0] b, logic [64:0] e);
        int t = 0;
        while (!ir[d] && t < 200) begin
            step();
            t++;
        end
        if (!ir[d]) begin
            n_vec++;
            n_bad++;
            $display("FAIL accept_timeout dut%0d: got IN_READY=0 want 1", d);
            return;
        end
        iv[d]   = 1'b1;
        a_in[d] = a;
        b_in[d] = b;
        @(posedge clk);
        sbq[d].push_back(e);
        #1;
        acc_cyc[d] = cyc;
        iv[d]   = 1'b0;
        a_in[d] = {$urandom, $urandom};
        b_in[d] = {$urandom, $urandom};
    endtask

    task automatic wait_drain(int d);
        int t = 0;
        while ((sbq[d].size() != 0 || ov[d]) && t < 500) begin
            step();
            t++;
        end
        n_vec++;
        if (sbq[d].size() != 0) begin
            n_bad++;
            $display("FAIL lost_result dut%0d: got %0d pending want 0",
                     d, sbq[d].size());
        end
    endtask

    bit rdone [3];

    task automatic rnd(int d, int n);
        logic [63:0] a, b;
        rdone[d] = 1'b0;
        fork
            begin
                for (int i = 0; i < n; i++) begin
                    repeat ($urandom_range(0, 3)) step();
                    a = {$urandom, $urandom};
                    b = {$urandom, $urandom};
                    if ($urandom_range(0, 3) == 0)
                        b = ~a + 64'($urandom_range(0, 2));
                    op(d, a, b, model(width_of(d), a, b));
                end
                rdone[d] = 1'b1;
            end
            begin
                while (!rdone[d]) begin
                    step();
                    ordy[d] = 1'($urandom_range(0, 1));
                end
                ordy[d] = 1'b1;
            end
        join
        wait_drain(d);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [64:0] e;
        vt[0] = '{0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, {1'b1, 64'h0}};
        vt[1] = '{0, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321,
                  {1'b0, 64'h2222_2222_2222_2211}};
        vt[2] = '{0, 64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001,
                  {1'b0, 64'h0001_0000_0001_0000}};
        vt[3] = '{0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                  {1'b1, 64'hFFFF_FFFF_FFFF_FFFE}};
        vt[4] = '{1, 64'h0FFF_FFFF_FFFF_FFFF, 64'h1, {1'b1, 64'h0}};
        vt[5] = '{1, 64'h0800_0000_0000_0000, 64'h07FF_FFFF_FFFF_FFFF,
                  {1'b0, 64'h0FFF_FFFF_FFFF_FFFF}};
        vt[6] = '{1, 64'h0800_0000_0000_0000, 64'h0800_0000_0000_0000,
                  {1'b1, 64'h0}};
        vt[7] = '{2, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
                  {1'b1, 64'h0}};
        vt[8] = '{2, 64'h5, 64'h3, {1'b0, 64'h8}};

        reset = 1'b1;
        iv    = '0;
        ordy  = '1;
        for (int d = 0; d < 3; d++) begin
            a_in[d] = '0;
            b_in[d] = '0;
            acc_cyc[d] = 0;
        end
        repeat (2) step();
        for (int d = 0; d < 3; d++) begin
            n_vec++;
            if ({ir[d], ov[d], got(d)} !== {2'b10, 65'h0}) begin
                n_bad++;
                $display("FAIL reset dut%0d: got rdy=%b vld=%b %h want 1 0 0",
                         d, ir[d], ov[d], got(d));
            end
        end
        reset = 1'b0;
        step();

        for (int v = 0; v < 9; v++) begin
            op(vt[v].d, vt[v].a, vt[v].b, vt[v].e);
            wait_drain(vt[v].d);
        end

        // Backpressure: result must hold while the consumer stalls.
        e = {1'b0, 64'hEFBE_D000_1234_5678};
        ordy[0] = 1'b0;
        op(0, 64'hDEAD_BEEF_0123_4567, 64'h1111_1111_1111_1111, e);
        for (int t = 0; t < 20 && !ov[0]; t++) step();
        for (int t = 0; t < 10; t++) begin
            n_vec++;
            if ({ov[0], ir[0], got(0)} !== {2'b10, e}) begin
                n_bad++;
                $display("FAIL hold cyc%0d: got vld=%b rdy=%b %h want 1 0 %h",
                         t, ov[0], ir[0], got(0), e);
            end
            iv[0]   = 1'b1;
            a_in[0] = {$urandom, $urandom};
            step();
        end
        ordy[0] = 1'b1;
        step();
        iv[0]   = 1'b0;
        n_vec++;
        if ({ov[0], ir[0]} !== 2'b01) begin
            n_bad++;
            $display("FAIL handoff: got vld=%b rdy=%b want 0 1", ov[0], ir[0]);
        end
        wait_drain(0);

        // Reset two cycles into ADD aborts the operation.
        iv[0]   = 1'b1;
        a_in[0] = 64'h1234_5678_9ABC_DEF0;
        b_in[0] = 64'h1111_1111_1111_1111;
        step();
        iv[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        n_vec++;
        if ({ov[0], ir[0], got(0)} !== {2'b01, 65'h0}) begin
            n_bad++;
            $display("FAIL abort: got vld=%b rdy=%b %h want 0 1 0",
                     ov[0], ir[0], got(0));
        end
        step();
        reset = 1'b0;
        repeat (6) step();
        n_vec++;
        if (ov[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_pulse: got vld=%b want 0", ov[0]);
        end
        op(0, 64'h5, 64'h3, {1'b0, 64'h8});
        wait_drain(0);

        fork
            rnd(0, 400);
            rnd(1, 400);
            rnd(2, 200);
        join

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
